decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the immediate output (sign-extended to this width; minimum 32).
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of the PC tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  / in_ready  output  1 -- fetch-side handshake; transfer occurs when both are high.
REQ-006 in_instr  input  32  instruction word; in_pc  input  ADDR_WIDTH  its address.
REQ-007 flush  input  1  discard all held and incoming instructions.
REQ-008 out_valid  output  1  / out_ready  input  1 -- execute-side handshake.
REQ-009 out_pc  output  ADDR_WIDTH; out_rd, out_rs1, out_rs2  output  5 each; out_funct3  output  3; out_funct7  output  7.
REQ-010 out_imm  output  DATA_WIDTH  sign-extended immediate.
REQ-011 out_alu_op  output  4  ALU operation code.
REQ-012 out_write_reg, out_alu_src, out_mem2reg, out_read_mem, out_write_mem, out_branch, out_jump, out_auipc, out_lui, out_muldiv, out_illegal  output  1 each.

Function
REQ-013 Block SHALL hold at most two decoded entries (output register + skid register), preserving program order.
REQ-014 in_ready SHALL equal (skid register empty) AND NOT rst.
REQ-015 Accepted instruction SHALL appear on outputs with out_valid=1 exactly one cycle after acceptance when the output register is empty or being drained that cycle; otherwise it SHALL enter the skid register.
REQ-016 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-017 When output register drains and skid is full, skid contents SHALL move to output register on the same edge; skid then empties.
REQ-018 Immediate: I-type imm[11:0]; S-type {instr[31:25],instr[11:7]}; B-type {instr[31],instr[7],instr[30:25],instr[11:8],0}; J-type {instr[31],instr[19:12],instr[20],instr[30:21],0}; U-type {instr[31:12],12'd0}; all SHALL be sign-extended from bit 31 of instr to DATA_WIDTH; R-type imm = 0.
REQ-019 Control per opcode: R: write_reg, alu_src=0; LOAD: write_reg, alu_src, mem2reg, read_mem; ALUI: write_reg, alu_src; JALR: write_reg, alu_src, jump; STORE: alu_src, write_mem; BRANCH: alu_src, branch; LUI: write_reg, alu_src, lui, out_rs1 forced 0; AUIPC: write_reg, alu_src, auipc; JAL: write_reg, alu_src, jump. Unlisted flags 0.
REQ-020 out_alu_op: R-type {instr[30],funct3}; ALUI {instr[30] if funct3==101 else 0, funct3}; all other opcodes 4'b0000.
REQ-021 out_illegal=1 for: instr[1:0]!=11, unknown opcode, R-type funct7 not 0000000/0100000 (see REQ-029), ALUI shift with funct7 not 0000000/0100000. Illegal entries SHALL still be delivered with out_valid=1 but all write/mem/branch/jump flags forced 0.
REQ-022 flush SHALL empty both entries on the next edge and discard any instruction transferred in the same cycle; flush has priority over accept and drain.
REQ-023 Simultaneous accept and drain with skid empty SHALL keep out_valid=1 with the new entry, no bubble.

Reset
REQ-024 While rst=1: both entries empty on next edge, out_valid=0, in_ready=0.
REQ-025 After reset all out_* data outputs SHALL be 0; in_ready=1 in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-operation SHALL discard held entries with no partial output.

Configuration
REQ-027 Macro DECODE_RV32M_EN selects M-extension decode.
REQ-028 Defined: R-type funct7=0000001 SHALL decode legal with out_muldiv=1, write_reg=1, out_alu_op={0,funct3}.
REQ-029 Undefined: funct7=0000001 SHALL set out_illegal=1; out_muldiv tied 0.

Verification
REQ-030 addi x1,x0,-1 (0xFFF00093) accepted -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, write_reg=1, alu_src=1, alu_op=0000.
REQ-031 beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, branch=1, write_reg=0, illegal=0.
REQ-032 out_ready=0, three back-to-back valid instrs -> two accepted, in_ready=0 after second; out_ready=1 -> drained in order, third accepted next cycle.
REQ-033 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-034 mul x3,x1,x2 (0x022081B3) -> macro defined: muldiv=1, illegal=0; undefined: illegal=1, write_reg=0.
REQ-035 rst=1 for one cycle while both entries full -> next cycle out_valid=0, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/decode_unit.sv
// decode_unit: RV32I instruction decoder with a two-entry elastic buffer
// (output register + skid register) between fetch and execute.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake; in_instr (32b), in_pc (ADDR_WIDTH)
//   flush                    drop both held entries and any same-cycle input
//   out_valid/out_ready      execute handshake
//   out_pc, out_rd/rs1/rs2, out_funct3, out_funct7, out_imm (DATA_WIDTH)
//   out_alu_op (4b), control flags (write_reg, alu_src, mem2reg, read_mem,
//   write_mem, branch, jump, auipc, lui, muldiv, illegal)
//
// Build option: define DECODE_RV32M_EN to decode the M extension
// (R-type funct7=0000001 as legal mul/div); otherwise it is illegal.
module decode_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [3:0]            out_alu_op,
  output logic                  out_write_reg,
  output logic                  out_alu_src,
  output logic                  out_mem2reg,
  output logic                  out_read_mem,
  output logic                  out_write_mem,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic                  out_auipc,
  output logic                  out_lui,
  output logic                  out_muldiv,
  output logic                  out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm;
    logic [3:0]            alu_op;
    logic                  write_reg;
    logic                  alu_src;
    logic                  mem2reg;
    logic                  read_mem;
    logic                  write_mem;
    logic                  branch;
    logic                  jump;
    logic                  auipc;
    logic                  lui;
    logic                  muldiv;
    logic                  illegal;
  } dec_t;

  // ---------------- combinational decode of the incoming word ----------------
  dec_t        dec;
  logic [31:0] imm32;
  logic [6:0]  f7;
  logic        f7_std;

  always_comb begin
    dec        = '0;
    imm32      = '0;
    f7         = in_instr[31:25];
    f7_std     = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    dec.pc     = in_pc;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = f7;
    // Opcode compare covers instr[1:0], so a non-32b encoding lands in default.
    case (in_instr[6:0])
      OP_R: begin
        dec.write_reg = 1'b1;
        dec.alu_op    = {in_instr[30], in_instr[14:12]};
        if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
          dec.muldiv = 1'b1;
          dec.alu_op = {1'b0, in_instr[14:12]};
`else
          dec.illegal = 1'b1;
`endif
        end else if (!f7_std) begin
          dec.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1;
        dec.mem2reg   = 1'b1; dec.read_mem = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_ALUI: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        // instr[30] only selects SRAI vs SRLI; other ALUI ops ignore it.
        dec.alu_op = {(in_instr[14:12] == 3'b101) && in_instr[30], in_instr[14:12]};
        if ((in_instr[13:12] == 2'b01) && !f7_std) dec.illegal = 1'b1;
      end
      OP_JALR: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.jump = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec.alu_src = 1'b1; dec.write_mem = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.alu_src = 1'b1; dec.branch = 1'b1;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.lui = 1'b1;
        dec.rs1 = 5'd0;
        imm32 = {in_instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.auipc = 1'b1;
        imm32 = {in_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.jump = 1'b1;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = DATA_WIDTH'($signed(imm32));
    // Illegal entries still flow to execute but must not change state.
    if (dec.illegal) begin
      dec.write_reg = 1'b0; dec.mem2reg  = 1'b0; dec.read_mem = 1'b0;
      dec.write_mem = 1'b0; dec.branch   = 1'b0; dec.jump     = 1'b0;
    end
  end

  // ---------------- two-entry buffer ----------------
  dec_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic fire_in, fire_out;

  assign in_ready = !skid_vld_q && !rst;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_vld_q && out_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || fire_out) begin
      // Output slot free this edge: skid (older) wins over new input.
      // in_ready is low whenever skid is full, so no input is lost here.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (fire_in) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (fire_in) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_pc        = out_q.pc;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_imm       = out_q.imm;
  assign out_alu_op    = out_q.alu_op;
  assign out_write_reg = out_q.write_reg;
  assign out_alu_src   = out_q.alu_src;
  assign out_mem2reg   = out_q.mem2reg;
  assign out_read_mem  = out_q.read_mem;
  assign out_write_mem = out_q.write_mem;
  assign out_branch    = out_q.branch;
  assign out_jump      = out_q.jump;
  assign out_auipc     = out_q.auipc;
  assign out_lui       = out_q.lui;
  assign out_muldiv    = out_q.muldiv;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
module tb_decode_unit;

`ifdef DECODE_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [3:0]  out_alu_op;
  logic out_write_reg, out_alu_src, out_mem2reg, out_read_mem, out_write_mem;
  logic out_branch, out_jump, out_auipc, out_lui, out_muldiv, out_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_write_reg(out_write_reg),
    .out_alu_src(out_alu_src), .out_mem2reg(out_mem2reg),
    .out_read_mem(out_read_mem), .out_write_mem(out_write_mem),
    .out_branch(out_branch), .out_jump(out_jump), .out_auipc(out_auipc),
    .out_lui(out_lui), .out_muldiv(out_muldiv), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic wr, src, m2r, rdm, wrm, br, jmp, auipc, lui, md, ill;
  } exp_t;

  exp_t act;
  assign act = {out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
                out_alu_op, out_write_reg, out_alu_src, out_mem2reg, out_read_mem,
                out_write_mem, out_branch, out_jump, out_auipc, out_lui, out_muldiv,
                out_illegal};

  // Reference decode, computed straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [6:0] f7;
    bit std7;
    f7   = i[31:25];
    std7 = (f7 == 7'h00) || (f7 == 7'h20);
    e = '0;
    e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.f3 = i[14:12]; e.f7 = f7;
    case (i[6:0])
      7'h33: begin
        e.wr = 1;
        e.alu_op = {i[30], i[14:12]};
        if (f7 == 7'h01) begin
          if (M_EN) begin e.md = 1; e.alu_op = {1'b0, i[14:12]}; end
          else e.ill = 1;
        end else e.ill = !std7;
      end
      7'h03: begin e.wr = 1; e.src = 1; e.m2r = 1; e.rdm = 1; e.imm = 32'($signed(i[31:20])); end
      7'h13: begin
        e.wr = 1; e.src = 1; e.imm = 32'($signed(i[31:20]));
        e.alu_op = {(i[14:12] == 3'd5) ? i[30] : 1'b0, i[14:12]};
        e.ill = (i[14:12] == 3'd1 || i[14:12] == 3'd5) && !std7;
      end
      7'h67: begin e.wr = 1; e.src = 1; e.jmp = 1; e.imm = 32'($signed(i[31:20])); end
      7'h23: begin e.src = 1; e.wrm = 1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h63: begin e.src = 1; e.br = 1;
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h37: begin e.wr = 1; e.src = 1; e.lui = 1; e.rs1 = 0; e.imm = {i[31:12], 12'h0}; end
      7'h17: begin e.wr = 1; e.src = 1; e.auipc = 1; e.imm = {i[31:12], 12'h0}; end
      7'h6f: begin e.wr = 1; e.src = 1; e.jmp = 1;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.wr = 0; e.m2r = 0; e.rdm = 0; e.wrm = 0; e.br = 0; e.jmp = 0; end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: r[6:0] = 7'h33;  1: r[6:0] = 7'h03;  2: r[6:0] = 7'h13;
      3: r[6:0] = 7'h67;  4: r[6:0] = 7'h23;  5: r[6:0] = 7'h63;
      6: r[6:0] = 7'h37;  7: r[6:0] = 7'h17;  8: r[6:0] = 7'h6f;
      9: r[6:0] = 7'h33;  10: r[1:0] = 2'($urandom_range(0, 2));
      default: ;
    endcase
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic idle();
    rst = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
  endtask

  // Present one word for a single edge, then return at the following negedge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk); in_valid = 1; in_instr = ins; in_pc = pc;
    @(negedge clk); in_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    checks++; if (act !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", act); end
  endtask

  task automatic test_addi();
    exp_t e;
    e = model(32'hFFF00093, 32'h100);
    out_ready = 1;
    send(32'hFFF00093, 32'h100); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
    checks++;
    if ({out_rd, out_rs1, out_imm, out_write_reg, out_alu_src, out_alu_op} !== {5'd1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd0}) begin
      failures++; $display("FAIL addi_fields got=%h/%h/%h/%b/%b/%h exp=1/0/ffffffff/1/1/0",
        out_rd, out_rs1, out_imm, out_write_reg, out_alu_src, out_alu_op);
    end
    checks++; if (act !== e) begin failures++; $display("FAIL addi_all got=%h exp=%h", act, e); end
  endtask

  task automatic test_beq();
    send(32'hFE000EE3, 32'h104); #1;
    checks++;
    if ({out_valid, out_imm, out_branch, out_write_reg, out_illegal} !== {1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL beq got=%b/%h/%b/%b/%b exp=1/fffffffc/1/0/0",
        out_valid, out_imm, out_branch, out_write_reg, out_illegal);
    end
  endtask

  task automatic test_mul();
    send(32'h022081B3, 32'h108); #1;
    checks++;
    if (M_EN) begin
      if ({out_muldiv, out_illegal, out_write_reg, out_alu_op} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
        failures++; $display("FAIL mul_m got=%b/%b/%b/%h exp=1/0/1/0", out_muldiv, out_illegal, out_write_reg, out_alu_op);
      end
    end else begin
      if ({out_muldiv, out_illegal, out_write_reg} !== {1'b0, 1'b1, 1'b0}) begin
        failures++; $display("FAIL mul_nom got=%b/%b/%b exp=0/1/0", out_muldiv, out_illegal, out_write_reg);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle();
    in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h10;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
    in_instr = 32'h00200113; in_pc = 32'h14;
    @(negedge clk);
    in_instr = 32'h00300193; in_pc = 32'h18; #1;
    checks++; if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h10}) begin
      failures++; $display("FAIL b2b_full got=%b/%b/%h exp=0/1/10", in_ready, out_valid, out_pc); end
    @(negedge clk); #1;
    checks++; if ({in_ready, out_pc} !== {1'b0, 32'h10}) begin
      failures++; $display("FAIL b2b_hold got=%b/%h exp=0/10", in_ready, out_pc); end
    out_ready = 1;
    @(negedge clk); #1;
    checks++; if ({out_valid, out_pc, in_ready} !== {1'b1, 32'h14, 1'b1}) begin
      failures++; $display("FAIL b2b_second got=%b/%h/%b exp=1/14/1", out_valid, out_pc, in_ready); end
    @(negedge clk); in_valid = 0; #1;
    checks++; if ({out_valid, out_pc} !== {1'b1, 32'h18}) begin
      failures++; $display("FAIL b2b_third got=%b/%h exp=1/18", out_valid, out_pc); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk); idle();
    send(32'h00100093, 32'h20);
    send(32'h00200113, 32'h24);
    in_valid = 1; in_instr = 32'h00300193; in_pc = 32'h28; flush = 1;
    @(negedge clk); in_valid = 0; flush = 0; #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_full got=%b/%b exp=0/1", out_valid, in_ready); end
    // One held entry plus a same-cycle transfer: both must vanish.
    send(32'h00100093, 32'h30);
    in_valid = 1; in_instr = 32'h00400213; in_pc = 32'h34; flush = 1;
    @(negedge clk); in_valid = 0; flush = 0; out_ready = 1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_xfer got=%b pc=%h exp=0", out_valid, out_pc); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle();
    send(32'h00100093, 32'h40);
    send(32'h00200113, 32'h44);
    rst = 1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", in_ready); end
    @(negedge clk); rst = 0; #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL rstmid_state got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (act !== '0) begin failures++; $display("FAIL rstmid_zero got=%h exp=0", act); end
    out_ready = 1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ghost got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    exp_t q[$];
    bit zero_exp;
    bit acc, drn;
    @(negedge clk); idle(); rst = 1;
    @(negedge clk);
    zero_exp = 1;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (out_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2 && !rst)) begin
        failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, in_ready, q.size() < 2 && !rst); end
      if (q.size() > 0) begin
        checks++; if (act !== q[0]) begin
          failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, act, q[0]); end
      end else if (zero_exp) begin
        checks++; if (act !== '0) begin
          failures++; $display("FAIL rnd_rstzero n=%0d got=%h exp=0", n, act); end
      end
      acc = in_valid && q.size() < 2 && !rst;
      drn = q.size() > 0 && out_ready;
      @(posedge clk);
      if (rst || flush) begin
        q.delete();
        zero_exp = rst || (zero_exp && !acc);
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin q.push_back(model(in_instr, in_pc)); zero_exp = 0; end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_addi();
    test_beq();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
